// File: rtl/nla_pkg.sv
// Shared definitions for the NLA input-buffer sequencer.
// Start marker, FSM state encoding and arbiter grant encoding.
package nla_pkg;

    localparam logic [31:0] START_WORD = 32'h7F90_0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    typedef enum logic {
        GNT_RD = 1'b0,
        GNT_WR = 1'b1
    } grant_e;

endpackage

// File: rtl/nla_fifo_sequencer_rr_arbiter2.sv
// Two-way round-robin arbiter for the single FIFO slot.
// Remembers the last side that actually transferred.
module rr_arbiter2
    import nla_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic req_wr_i,
    input  logic req_rd_i,
    input  logic xfer_wr_i,
    input  logic xfer_rd_i,
    output logic gnt_wr_o,
    output logic gnt_rd_o
);

    grant_e last_q;
    grant_e last_d;

    always_comb begin
        last_d = last_q;
        if (xfer_wr_i) begin
            last_d = GNT_WR;
        end else if (xfer_rd_i) begin
            last_d = GNT_RD;
        end
    end

    assign gnt_wr_o = req_wr_i & (!req_rd_i | (last_q == GNT_RD));
    assign gnt_rd_o = req_rd_i & (!req_wr_i | (last_q == GNT_WR));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_q <= GNT_RD;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/nla_fifo_sequencer.sv
// Sequencer for the NLA input-buffer FIFO: frames upstream packets,
// shares the FIFO slot between writes and reads, feeds the engine.
module nla_fifo_sequencer #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_LINES = 12,
    parameter int LEN_W      = 13,
    parameter logic [DATA_WIDTH-1:0] START_WORD =
        DATA_WIDTH'(nla_pkg::START_WORD)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  src_valid_i,
    input  logic [DATA_WIDTH-1:0] src_data_i,
    output logic                  src_ready_o,
    input  logic [LEN_W-1:0]      len_i,
    output logic                  fifo_wr_en_o,
    output logic [DATA_WIDTH-1:0] fifo_data_o,
    output logic                  fifo_rd_en_o,
    input  logic [DATA_WIDTH-1:0] fifo_data_i,
    input  logic                  fifo_full_i,
    input  logic                  fifo_empty_i,
    output logic                  eng_valid_o,
    output logic [DATA_WIDTH-1:0] eng_data_o,
    output logic                  eng_last_o,
    input  logic                  eng_ready_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o
);

    import nla_pkg::*;

    localparam logic [ADDR_LINES:0] DEPTH = {1'b1, {ADDR_LINES{1'b0}}};

    state_e                  state_q, state_d;
    logic [LEN_W-1:0]        len_q, len_d;
    logic [LEN_W-1:0]        wr_cnt_q, wr_cnt_d;
    logic [LEN_W-1:0]        rd_cnt_q, rd_cnt_d;
    logic [ADDR_LINES:0]     occ_q, occ_d;
    logic                    infl_q, infl_d;
    logic                    slot_vld_q, slot_vld_d;
    logic [DATA_WIDTH-1:0]   slot_data_q, slot_data_d;
    logic                    slot_last_q, slot_last_d;
    logic                    err_q, err_d;

    logic in_load, in_rd, is_marker, slot_free;
    logic wr_cand, rd_cand, gnt_wr, gnt_rd;
    logic ready_int, accept, wr_en, rd_en, eng_hs, flag_err;

    assign in_load   = (state_q == ST_LOAD);
    assign in_rd     = in_load | (state_q == ST_DRAIN);
    assign is_marker = (src_data_i == START_WORD);
    assign slot_free = !slot_vld_q | eng_ready_i;

    assign wr_cand = in_load & (occ_q < DEPTH) & !fifo_full_i;
    assign rd_cand = in_rd & (occ_q != '0) & !fifo_empty_i
                   & (rd_cnt_q < len_q) & !infl_q & slot_free;

    rr_arbiter2 u_arb (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .req_wr_i  (wr_cand),
        .req_rd_i  (rd_cand),
        .xfer_wr_i (wr_en),
        .xfer_rd_i (rd_en),
        .gnt_wr_o  (gnt_wr),
        .gnt_rd_o  (gnt_rd)
    );

    // Ready follows the write grant only, never the source's valid.
    assign ready_int = (state_q == ST_IDLE) | gnt_wr;
    assign accept    = src_valid_i & src_ready_o;
    assign wr_en     = in_load & accept & !is_marker;
    assign rd_en     = gnt_rd & !rst_i;
    assign eng_hs    = slot_vld_q & eng_ready_i;

    // Flag/occupancy disagreement means the FIFO and our count diverged.
    assign flag_err = ((occ_q != '0) & fifo_empty_i)
                    | ((occ_q < DEPTH) & fifo_full_i);

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        wr_cnt_d    = wr_cnt_q;
        rd_cnt_d    = rd_cnt_q;
        occ_d       = occ_q;
        infl_d      = rd_en;
        slot_vld_d  = slot_vld_q;
        slot_data_d = slot_data_q;
        slot_last_d = slot_last_q;
        err_d       = err_q | flag_err;

        if (wr_en) begin
            wr_cnt_d = wr_cnt_q + LEN_W'(1);
            occ_d    = occ_q + (ADDR_LINES+1)'(1);
        end
        if (rd_en) begin
            rd_cnt_d = rd_cnt_q + LEN_W'(1);
            occ_d    = occ_q - (ADDR_LINES+1)'(1);
        end

        if (infl_q) begin
            slot_vld_d  = 1'b1;
            slot_data_d = fifo_data_i;
            slot_last_d = (rd_cnt_q == len_q);
        end else if (eng_hs) begin
            slot_vld_d  = 1'b0;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (accept && is_marker) begin
                    if (len_i == '0) begin
                        err_d = 1'b1;
                    end else begin
                        len_d    = len_i;
                        wr_cnt_d = '0;
                        rd_cnt_d = '0;
                        state_d  = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                if (accept && is_marker) begin
                    err_d = 1'b1;
                end
                if (wr_en && (wr_cnt_q + LEN_W'(1) == len_q)) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (eng_hs && slot_last_q) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
            occ_q       <= '0;
            infl_q      <= 1'b0;
            slot_vld_q  <= 1'b0;
            slot_data_q <= '0;
            slot_last_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            occ_q       <= occ_d;
            infl_q      <= infl_d;
            slot_vld_q  <= slot_vld_d;
            slot_data_q <= slot_data_d;
            slot_last_q <= slot_last_d;
            err_q       <= err_d;
        end
    end

    assign src_ready_o  = ready_int & !rst_i;
    assign fifo_wr_en_o = wr_en;
    assign fifo_data_o  = wr_en ? src_data_i : '0;
    assign fifo_rd_en_o = rd_en;
    assign eng_valid_o  = slot_vld_q;
    assign eng_data_o   = slot_data_q;
    assign eng_last_o   = slot_vld_q & slot_last_q;
    assign busy_o       = (state_q != ST_IDLE);
    assign done_o       = (state_q == ST_DONE);
    assign err_o        = err_q;

endmodule

// File: tb/tb_nla_fifo_sequencer.sv
// Directed bench for nla_fifo_sequencer with a small FIFO model.
// Uses a 16-deep FIFO so the full/stall case stays short.
module tb_nla_fifo_sequencer;

    localparam int AL  = 4;
    localparam int LW  = 6;
    localparam int DEP = 16;
    localparam logic [31:0] SW = 32'h7F90_0000;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          src_valid;
    logic [31:0]   src_data;
    logic          src_ready;
    logic [LW-1:0] len_in;
    logic          fifo_wr_en;
    logic [31:0]   fifo_wdata;
    logic          fifo_rd_en;
    logic [31:0]   frd;
    logic          fifo_full;
    logic          fifo_empty;
    logic          eng_valid;
    logic [31:0]   eng_data;
    logic          eng_last;
    logic          eng_ready;
    logic          busy;
    logic          done;
    logic          err;

    always #5 clk = ~clk;

    nla_fifo_sequencer #(
        .DATA_WIDTH (32),
        .ADDR_LINES (AL),
        .LEN_W      (LW),
        .START_WORD (SW)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .src_valid_i  (src_valid),
        .src_data_i   (src_data),
        .src_ready_o  (src_ready),
        .len_i        (len_in),
        .fifo_wr_en_o (fifo_wr_en),
        .fifo_data_o  (fifo_wdata),
        .fifo_rd_en_o (fifo_rd_en),
        .fifo_data_i  (frd),
        .fifo_full_i  (fifo_full),
        .fifo_empty_i (fifo_empty),
        .eng_valid_o  (eng_valid),
        .eng_data_o   (eng_data),
        .eng_last_o   (eng_last),
        .eng_ready_i  (eng_ready),
        .busy_o       (busy),
        .done_o       (done),
        .err_o        (err)
    );

    // external FIFO: write wins, registered read data
    logic [31:0] fmem [DEP];
    logic [3:0]  fwp, frp;
    logic [4:0]  fcnt;

    always @(posedge clk) begin
        if (rst_i) begin
            fwp  <= '0;
            frp  <= '0;
            fcnt <= '0;
            frd  <= '0;
        end else if (fifo_wr_en) begin
            fmem[fwp] <= fifo_wdata;
            fwp       <= fwp + 4'd1;
            fcnt      <= fcnt + 5'd1;
        end else if (fifo_rd_en) begin
            frd  <= fmem[frp];
            frp  <= frp + 4'd1;
            fcnt <= fcnt - 5'd1;
        end
    end

    assign fifo_full  = (fcnt == 5'd16);
    assign fifo_empty = (fcnt == 5'd0);

    // monitor, sampled on the falling edge
    logic [31:0] rx[$];
    int m_wr = 0, m_rd = 0, m_both = 0, m_done = 0, m_nlast = 0;
    int m_lastidx = -1, m_stall = 0, m_stall_rd = 0, m_stall_bad = 0;
    logic [31:0] m_seq = '0;
    logic [31:0] held;
    logic        held_vld = 1'b0;

    always @(negedge clk) begin
        if (fifo_wr_en && fifo_rd_en) m_both++;
        if (fifo_wr_en) begin
            m_wr++;
            m_seq = {m_seq[30:0], 1'b1};
        end
        if (fifo_rd_en) begin
            m_rd++;
            m_seq = {m_seq[30:0], 1'b0};
        end
        if (eng_valid && eng_ready) begin
            rx.push_back(eng_data);
            if (eng_last) begin
                m_nlast++;
                m_lastidx = rx.size() - 1;
            end
        end
        if (done) m_done++;
        if (eng_valid && !eng_ready) begin
            m_stall++;
            if (fifo_rd_en) m_stall_rd++;
            if (held_vld && eng_data != held) m_stall_bad++;
            held     = eng_data;
            held_vld = 1'b1;
        end else begin
            held_vld = 1'b0;
        end
    end

    int n_tot = 0, n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int b_rx, b_wr, b_rd, b_both, b_done, b_nlast, b_stall, b_srd, b_sbad;

    task automatic snap();
        b_rx    = rx.size();
        b_wr    = m_wr;
        b_rd    = m_rd;
        b_both  = m_both;
        b_done  = m_done;
        b_nlast = m_nlast;
        b_stall = m_stall;
        b_srd   = m_stall_rd;
        b_sbad  = m_stall_bad;
    endtask

    logic [31:0] txq[$];

    task automatic send(input logic [LW-1:0] len);
        int   acc;
        int   tmo;
        logic ok;
        acc       = 0;
        tmo       = 0;
        src_valid = 1'b1;
        src_data  = txq[0];
        len_in    = len;
        while (acc < txq.size() && tmo < 3000) begin
            @(negedge clk);
            ok = src_ready;
            @(posedge clk);
            #1;
            tmo++;
            if (ok) begin
                acc++;
                if (acc < txq.size()) src_data = txq[acc];
            end
        end
        src_valid = 1'b0;
        chk("src_accepted", 64'(acc), 64'(txq.size()));
    endtask

    task automatic wait_done(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        chk({tag, "_done_seen"}, 64'(seen), 64'd1);
        step();
    endtask

    task automatic fill_txq(input int n, input logic [31:0] base);
        txq = {};
        txq.push_back(SW);
        for (int i = 0; i < n; i++) txq.push_back(base + 32'(i));
    endtask

    task automatic check_rx(input string tag, input int n,
                            input logic [31:0] base);
        int nb;
        nb = 0;
        chk({tag, "_rx_count"}, 64'(rx.size() - b_rx), 64'(n));
        for (int i = 0; i < n && b_rx + i < rx.size(); i++)
            if (rx[b_rx + i] !== base + 32'(i)) nb++;
        chk({tag, "_rx_order"}, 64'(nb), 64'd0);
        chk({tag, "_last_idx"}, 64'(m_lastidx), 64'(b_rx + n - 1));
        chk({tag, "_last_cnt"}, 64'(m_nlast - b_nlast), 64'd1);
        chk({tag, "_done_cnt"}, 64'(m_done - b_done), 64'd1);
        chk({tag, "_no_both"}, 64'(m_both - b_both), 64'd0);
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        step();
        step();
        rst_i = 1'b0;
        step();
    endtask

    initial begin
        rst_i     = 1'b1;
        src_valid = 1'b0;
        src_data  = '0;
        len_in    = '0;
        eng_ready = 1'b0;

        // reset values
        @(negedge clk);
        chk("rst_src_ready", 64'(src_ready), 64'd0);
        step();
        rst_i = 1'b0;
        @(negedge clk);
        chk("rst_flags", 64'({fifo_wr_en, fifo_rd_en, eng_valid,
            eng_last, busy, done, err}), 64'd0);
        chk("rst_data", 64'({eng_data, fifo_wdata}), 64'd0);
        chk("idle_ready", 64'(src_ready), 64'd1);
        step();

        // basic packet of four
        snap();
        fill_txq(4, 32'd1);
        eng_ready = 1'b1;
        send(6'd4);
        wait_done("t1");
        check_rx("t1", 4, 32'd1);
        chk("t1_writes", 64'(m_wr - b_wr), 64'd4);
        chk("t1_reads", 64'(m_rd - b_rd), 64'd4);
        chk("t1_grants", 64'(m_seq[7:0]), 64'hAA);
        chk("t1_err", 64'(err), 64'd0);
        chk("t1_idle", 64'(busy), 64'd0);

        // eight words, grants alternate W R W R ...
        snap();
        fill_txq(8, 32'h100);
        send(6'd8);
        wait_done("t2");
        check_rx("t2", 8, 32'h100);
        chk("t2_grants", 64'(m_seq[15:0]), 64'hAAAA);

        // DEPTH+4 words, engine held off until the FIFO is full
        snap();
        fill_txq(DEP + 4, 32'h200);
        eng_ready = 1'b0;
        fork
            send(6'(DEP + 4));
            begin
                bit hit;
                hit = 1'b0;
                for (int i = 0; i < 500; i++) begin
                    step();
                    if (fcnt == 5'd16) begin
                        hit = 1'b1;
                        break;
                    end
                end
                chk("t3_fill", 64'(hit), 64'd1);
                step();
                step();
                @(negedge clk);
                chk("t3_ready_full", 64'(src_ready), 64'd0);
                chk("t3_head_valid", 64'(eng_valid), 64'd1);
                chk("t3_head_data", 64'(eng_data), 64'h200);
                step();
                eng_ready = 1'b1;
            end
        join
        wait_done("t3");
        check_rx("t3", DEP + 4, 32'h200);
        chk("t3_err", 64'(err), 64'd0);

        // engine stalls five cycles mid-packet
        snap();
        fill_txq(8, 32'h300);
        fork
            send(6'd8);
            begin
                bit hit;
                hit = 1'b0;
                for (int i = 0; i < 200; i++) begin
                    step();
                    if (rx.size() >= b_rx + 2) begin
                        hit = 1'b1;
                        break;
                    end
                end
                chk("t4_reach", 64'(hit), 64'd1);
                eng_ready = 1'b0;
                repeat (5) step();
                eng_ready = 1'b1;
            end
        join
        wait_done("t4");
        check_rx("t4", 8, 32'h300);
        chk("t4_stalled", 64'(m_stall != b_stall), 64'd1);
        chk("t4_hold", 64'(m_stall_bad - b_sbad), 64'd0);
        chk("t4_no_rd", 64'(m_stall_rd - b_srd), 64'd0);
        chk("t4_err", 64'(err), 64'd0);

        // zero-length marker
        do_reset();
        src_valid = 1'b1;
        src_data  = SW;
        len_in    = '0;
        step();
        src_valid = 1'b0;
        @(negedge clk);
        chk("t5_len0_err", 64'(err), 64'd1);
        chk("t5_len0_idle", 64'(busy), 64'd0);
        step();
        step();
        @(negedge clk);
        chk("t5_err_sticky", 64'(err), 64'd1);

        // marker inside a packet is swallowed
        do_reset();
        snap();
        txq = {SW, 32'h30, SW, 32'h31, 32'h32};
        eng_ready = 1'b1;
        send(6'd3);
        wait_done("t5b");
        chk("t5b_rx_count", 64'(rx.size() - b_rx), 64'd3);
        chk("t5b_rx_mid", 64'(rx[b_rx + 1]), 64'h31);
        chk("t5b_writes", 64'(m_wr - b_wr), 64'd3);
        chk("t5b_err", 64'(err), 64'd1);

        // reset while draining
        do_reset();
        fill_txq(6, 32'h40);
        eng_ready = 1'b0;
        send(6'd6);
        @(negedge clk);
        chk("t6_busy", 64'(busy), 64'd1);
        chk("t6_slot", 64'(eng_valid), 64'd1);
        step();
        rst_i = 1'b1;
        @(negedge clk);
        chk("t6_rst_ready", 64'(src_ready), 64'd0);
        step();
        rst_i = 1'b0;
        @(negedge clk);
        chk("t6_flags", 64'({fifo_wr_en, fifo_rd_en, eng_valid,
            eng_last, busy, done, err}), 64'd0);
        chk("t6_data", 64'({eng_data, fifo_wdata}), 64'd0);
        chk("t6_idle_ready", 64'(src_ready), 64'd1);
        step();

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
